// File: rtl/tank_level_tracker.sv
// tank_level_tracker: debounced N-probe thermometer level tracker; define FAULT_LATCH_EN to latch invalid readings in a FAULT state
module tank_level_tracker #(
    parameter int N_LEVELS = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N_LEVELS-1:0]             sensor,
    output logic [N_LEVELS-1:0]             level,
    output logic [$clog2(N_LEVELS+1)-1:0]   level_idx,
    output logic                            dir_up,
    output logic                            step,
    output logic                            valid,
    output logic                            sensor_err
);
    localparam int IW = $clog2(N_LEVELS + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
`ifdef FAULT_LATCH_EN
    localparam logic [1:0] FAULT = 2'd2;
`endif
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          st;
    logic [N_LEVELS-1:0] samp, tgt, tgt_inc;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       tgt_idx;
    logic                first, have, tgt_ok;

    function automatic logic [IW-1:0] ones(input logic [N_LEVELS-1:0] v);
        ones = '0;
        for (int i = 0; i < N_LEVELS; i++) ones = ones + IW'(v[i]);
    endfunction

    assign level_idx = ones(level);
    assign tgt_idx   = ones(tgt);
    assign tgt_inc   = tgt + N_LEVELS'(1);
    // contiguous ones from bit0 iff adding one clears every set bit
    assign tgt_ok    = ~|(tgt & tgt_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            level      <= '0;
            dir_up     <= 1'b0;
            step       <= 1'b0;
            valid      <= 1'b0;
            sensor_err <= 1'b0;
            samp       <= '0;
            cnt        <= '0;
            tgt        <= '0;
            first      <= 1'b1;
            have       <= 1'b0;
        end else begin
            step <= 1'b0;
            if (st == IDLE) begin
                valid <= 1'b0;
                if (start) begin
                    st    <= TRACK;
                    cnt   <= '0;
                    first <= 1'b1;
                    have  <= 1'b0;
                end
            end else if (!start) begin
                st    <= IDLE;
                valid <= 1'b0;
`ifdef FAULT_LATCH_EN
                if (st == FAULT) sensor_err <= 1'b0;
`endif
            end else if (st == TRACK) begin
                if (sensor != samp) begin
                    samp <= sensor;
                    cnt  <= CW'(1);
                end else begin
                    if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                    if (cnt == CNT_ACC) begin
                        tgt  <= sensor;
                        have <= 1'b1;
                    end
                end
                if (have) begin
                    if (!tgt_ok) begin
                        sensor_err <= 1'b1;
`ifdef FAULT_LATCH_EN
                        st    <= FAULT;
                        valid <= 1'b0;
`endif
                    end else begin
                        sensor_err <= 1'b0;
                        if (first) begin
                            level <= tgt;
                            valid <= 1'b1;
                            first <= 1'b0;
                            step  <= (tgt != level);
                            if (tgt_idx != level_idx) dir_up <= (tgt_idx > level_idx);
                        end else if (tgt_idx > level_idx) begin
                            level  <= {level[N_LEVELS-2:0], 1'b1};
                            dir_up <= 1'b1;
                            step   <= 1'b1;
                        end else if (tgt_idx < level_idx) begin
                            level  <= level >> 1;
                            dir_up <= 1'b0;
                            step   <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/tank_level_tracker.md
Name: tank_level_tracker

Overview:
- Parametrised successor to the fixed three-probe H/M/L level register in the irrigation box.
- Tracks N wet/dry level probes, debounces them and validates the thermometer pattern.
- Moves the reported level one step per clock toward the accepted reading, with direction and change flags.
- Feeds the pump and valve controller, which consumes level_idx, dir_up and step.

Parameters:
N_LEVELS, 3, number of probes (≥2); bit0 = lowest probe
DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a reading (≥2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  level enable; tracking runs only while high
sensor  in  N_LEVELS  raw probe inputs, 1 = wet
level  out  N_LEVELS  tracked level, thermometer code
level_idx  out  $clog2(N_LEVELS+1)  number of ones in level (0..N_LEVELS)
dir_up  out  1  direction of last step (1 = rising)
step  out  1  one-cycle pulse on any change of level
valid  out  1  tracker holds an accepted reading
sensor_err  out  1  accepted reading is not a thermometer code

Behaviour:
- One clock domain; reset is synchronous and active-high, on port rst, clock port clk. All state changes on the rising clk edge.
- Reset (rst=1 at an edge): state=IDLE; level, level_idx, dir_up, step, valid, sensor_err = 0; samp=0, cnt=0, first=1. rst dominates start.
- States:
  - IDLE: start=1 → TRACK, with cnt=0 and first=1 on entry.
  - TRACK: start=0 → IDLE. Invalid accepted reading with FAULT_LATCH_EN defined → FAULT.
  - FAULT: start=0 → IDLE.
- IDLE: level, level_idx and dir_up hold; valid=0; step=0.
- Debounce (TRACK only):
  - sensor≠samp: samp←sensor, cnt←1.
  - Otherwise cnt increments, saturating at DEBOUNCE_CYCLES.
  - When cnt==DEBOUNCE_CYCLES-1 and sensor==samp: tgt←sensor (accept).
  - An accepted reading applies on the next edge, so level first changes on the (DEBOUNCE_CYCLES+1)th edge that samples the new value.
  - A glitch shorter than DEBOUNCE_CYCLES samples never reaches tgt.
- Validation: tgt is valid iff its ones are contiguous from bit0 (000, 001, 011, 111 for N=3).
- Tracking, valid tgt:
  - First accept after entering TRACK (first=1): level←tgt directly. valid←1, first←0. step=1 if level changed. dir_up=1 if new idx > old idx, holds if equal.
  - Afterwards, idx(tgt)>level_idx: level←{level,1} truncated, dir_up=1, step=1.
  - idx(tgt)<level_idx: level←level>>1, dir_up=0, step=1.
  - Equal: hold, step=0.
  - One step per clock; a 0→N jump takes N cycles.
  - level_idx always equals popcount(level) in the same cycle.
- Invalid tgt, default build: sensor_err=1, level holds, step=0, valid stays 1. sensor_err clears on the edge applying the next valid accept.
- start falling mid-ramp: IDLE on the next edge; the pending step in that cycle is suppressed; level frozen.
- start high again: re-debounce from cnt=0, then first-accept load.

Optional Feature:
FAULT_LATCH_EN
- Defined: an invalid accepted reading → FAULT on the next edge. In FAULT, sensor_err=1 (sticky), valid=0, level holds, step=0, and valid readings are ignored. Exit only via start=0 (→IDLE, sensor_err←0) or rst.
- Undefined: FAULT state is absent; the default non-latching error behaviour applies.

Test Plan:
- rst=1 for 2 edges, start=1, sensor=111 → all outputs 0 during and after reset edge; rst has priority over start.
- N=3, D=4: start=1, sensor=011 held → level=011, level_idx=2, valid=1, step pulse on the 5th edge after sampling; dir_up=1.
- Tracking at 011, sensor=111 for 3 cycles then back to 011 → no step, level stays 011.
- Tracking at 001, sensor=111 held → after accept, level=011 then 111 on consecutive edges; two step pulses; dir_up=1. Then sensor=000 → 011, 001, 000; dir_up=0.
- Tracking at 011, sensor=101 held → sensor_err=1, level=011 held.
  - Default build: sensor=001 clears sensor_err and steps to 001.
  - FAULT_LATCH_EN: sensor_err stays 1 and valid=0 until start=0.
- Ramp 000→111 in progress, start=0 at level=011 → level frozen at 011, valid=0, no further step; start=1 with sensor=111 → reload to 111 after debounce.
